dm_arbiter: RTL and testbench

- Two-requester arbiter sharing the single Data_Memory port between the CPU datapath (requester 0) and an I/O DMA engine (requester 1).
- Sits between the MCU/integer datapath, the DMA engine and the data memory.
- Sequences each access as IDLE -> ACCESS -> ACK.
- Arbitrates ties round-robin and stalls the CPU while it waits.

---
 rtl/dm_arbiter.sv | 151 +++++++++++++++
 tb/tb_dm_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU datapath
// (requester 0) and the I/O DMA engine (requester 1).
module dm_arbiter #(
  parameter int ACC_CYC = 1,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          io_req,
  input  logic          io_wr,
  input  logic [AW-1:0] io_addr,
  input  logic [DW-1:0] io_wdata,
  output logic          io_ack,
  output logic [DW-1:0] rdata,
  output logic          owner,
  output logic          busy,
  output logic          dm_cs,
  output logic          dm_rd,
  output logic          dm_wr,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  input  logic [DW-1:0] dm_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          cs_q, cs_d;
  logic          rd_q, rd_d;
  logic          wrs_q, wrs_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          io_ack_q, io_ack_d;
  logic          grant_io;
  logic          sel_wr;

  // owner resets to 1 so that the CPU wins the first tie.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b1;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      rdata_q   <= '0;
      cs_q      <= 1'b0;
      rd_q      <= 1'b0;
      wrs_q     <= 1'b0;
      cpu_ack_q <= 1'b0;
      io_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      rdata_q   <= rdata_d;
      cs_q      <= cs_d;
      rd_q      <= rd_d;
      wrs_q     <= wrs_d;
      cpu_ack_q <= cpu_ack_d;
      io_ack_q  <= io_ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    din_d     = din_q;
    rdata_d   = rdata_q;
    cs_d      = 1'b0;
    rd_d      = 1'b0;
    wrs_d     = 1'b0;
    cpu_ack_d = 1'b0;
    io_ack_d  = 1'b0;
    // On a tie the requester that did not own the port last time wins.
    grant_io  = io_req & (~cpu_req | ~owner_q);
    sel_wr    = grant_io ? io_wr : cpu_wr;

    unique case (state_q)
      IDLE: begin
        if (cpu_req || io_req) begin
          owner_d = grant_io;
          wr_d    = sel_wr;
          addr_d  = grant_io ? io_addr : cpu_addr;
          din_d   = grant_io ? io_wdata : cpu_wdata;
          cnt_d   = 4'(ACC_CYC - 1);
          cs_d    = 1'b1;
          rd_d    = ~sel_wr;
          wrs_d   = sel_wr;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          cs_d  = 1'b1;
          rd_d  = ~wr_q;
          wrs_d = wr_q;
        end else begin
          if (!wr_q) begin
            rdata_d = dm_dout;
          end
          cpu_ack_d = ~owner_q;
          io_ack_d  = owner_q;
          state_d   = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cpu_ack   = cpu_ack_q;
  assign io_ack    = io_ack_q;
  assign cpu_stall = cpu_req & ~cpu_ack_q;
  assign rdata     = rdata_q;
  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);
  assign dm_cs     = cs_q;
  assign dm_rd     = rd_q;
  assign dm_wr     = wrs_q;
  assign dm_addr   = addr_q;
  assign dm_din    = din_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: a per-cycle vector table on an ACC_CYC=1
// instance plus hand-written multi-cycle sequences on ACC_CYC=1 and ACC_CYC=3.
module tb_dm_arbiter;

  logic sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  int checks   = 0;
  int failures = 0;

  // Instance 1: ACC_CYC = 1
  logic        reset1;
  logic        cpuReq1, cpuWr1, ioReq1, ioWr1;
  logic [31:0] cpuAddr1, cpuData1, ioAddr1, ioData1;
  logic        cpuAck1, cpuStall1, ioAck1, owner1, busy1, dmCs1, dmRd1, dmWr1;
  logic [31:0] rdata1, dmAddr1, dmDin1, dmDout1;

  // Instance 2: ACC_CYC = 3
  logic        reset2;
  logic        cpuReq2;
  logic [31:0] cpuAddr2;
  logic        ioReq2 = 1'b0;
  logic        cpuAck2, cpuStall2, ioAck2, owner2, busy2, dmCs2, dmRd2, dmWr2;
  logic [31:0] rdata2, dmAddr2, dmDin2, dmDout2;
  logic [31:0] cyc2 = '0;

  dm_arbiter #(.ACC_CYC(1), .AW(32), .DW(32)) dut1 (
    .sys_clk(sysClk), .reset(reset1),
    .cpu_req(cpuReq1), .cpu_wr(cpuWr1), .cpu_addr(cpuAddr1), .cpu_wdata(cpuData1),
    .cpu_ack(cpuAck1), .cpu_stall(cpuStall1),
    .io_req(ioReq1), .io_wr(ioWr1), .io_addr(ioAddr1), .io_wdata(ioData1),
    .io_ack(ioAck1), .rdata(rdata1), .owner(owner1), .busy(busy1),
    .dm_cs(dmCs1), .dm_rd(dmRd1), .dm_wr(dmWr1), .dm_addr(dmAddr1),
    .dm_din(dmDin1), .dm_dout(dmDout1)
  );

  dm_arbiter #(.ACC_CYC(3), .AW(32), .DW(32)) dut2 (
    .sys_clk(sysClk), .reset(reset2),
    .cpu_req(cpuReq2), .cpu_wr(1'b0), .cpu_addr(cpuAddr2), .cpu_wdata(32'h0),
    .cpu_ack(cpuAck2), .cpu_stall(cpuStall2),
    .io_req(ioReq2), .io_wr(1'b0), .io_addr(32'h0), .io_wdata(32'h0),
    .io_ack(ioAck2), .rdata(rdata2), .owner(owner2), .busy(busy2),
    .dm_cs(dmCs2), .dm_rd(dmRd2), .dm_wr(dmWr2), .dm_addr(dmAddr2),
    .dm_din(dmDin2), .dm_dout(dmDout2)
  );

  // Memory model for instance 1: preloaded words until overwritten.
  logic [31:0] mem [0:255];
  logic [255:0] memValid = '0;

  function automatic logic [31:0] preload(input logic [7:0] a);
    case (a)
      8'h10:   return 32'hDEADBEEF;
      8'h30:   return 32'h0BADF00D;
      default: return 32'h0;
    endcase
  endfunction

  assign dmDout1 = memValid[dmAddr1[7:0]] ? mem[dmAddr1[7:0]] : preload(dmAddr1[7:0]);

  always @(posedge sysClk) begin
    if (dmCs1 && dmWr1) begin
      mem[dmAddr1[7:0]]      <= dmDin1;
      memValid[dmAddr1[7:0]] <= 1'b1;
    end
  end

  // Instance 2 memory returns a value that changes every cycle, so the
  // captured rdata reveals which access cycle it was sampled in.
  always @(posedge sysClk) cyc2 <= cyc2 + 32'd1;
  assign dmDout2 = 32'hC0DE0000 | {16'h0, cyc2[15:0]};

  typedef struct {
    logic        cReq, cWr;
    logic [31:0] cAddr, cData;
    logic        iReq, iWr;
    logic [31:0] iAddr, iData;
    logic        eCAck, eIAck, eCs, eRd, eWr, eOwner, eBusy, eStall;
    logic [31:0] eAddr, eDin, eRdata;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    cpuReq1  = v.cReq;  cpuWr1 = v.cWr;  cpuAddr1 = v.cAddr;  cpuData1 = v.cData;
    ioReq1   = v.iReq;  ioWr1  = v.iWr;  ioAddr1  = v.iAddr;  ioData1  = v.iData;
  endtask

  task automatic checkVector(input int i, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", i);
    checkOutput({tag, "_cpu_ack"}, cpuAck1, v.eCAck);
    checkOutput({tag, "_io_ack"}, ioAck1, v.eIAck);
    checkOutput({tag, "_dm_cs"}, dmCs1, v.eCs);
    checkOutput({tag, "_dm_rd"}, dmRd1, v.eRd);
    checkOutput({tag, "_dm_wr"}, dmWr1, v.eWr);
    checkOutput({tag, "_owner"}, owner1, v.eOwner);
    checkOutput({tag, "_busy"}, busy1, v.eBusy);
    checkOutput({tag, "_stall"}, cpuStall1, v.eStall);
    checkOutput({tag, "_dm_addr"}, dmAddr1, v.eAddr);
    checkOutput({tag, "_dm_din"}, dmDin1, v.eDin);
    checkOutput({tag, "_rdata"}, rdata1, v.eRdata);
  endtask

  initial begin
    int ackCount;
    int expWho;
    int csCount;
    int ackCycle;
    int gotAcks;
    logic [31:0] expRdata;

    // Rows: cpu inputs, io inputs, then cpuAck ioAck cs rd wr owner busy stall, addr din rdata
    vecs[0] = '{1,0,32'h10,0, 0,0,0,0,                   0,0,0,0,0,1,0,1, 32'h00,32'h0,32'h0};
    vecs[1] = '{1,0,32'h10,0, 0,0,0,0,                   0,0,1,1,0,0,1,1, 32'h10,32'h0,32'h0};
    vecs[2] = '{1,0,32'h10,0, 0,0,0,0,                   1,0,0,0,0,0,1,0, 32'h10,32'h0,32'hDEADBEEF};
    vecs[3] = '{0,0,0,0,      1,1,32'h20,32'h12345678,   0,0,0,0,0,0,0,0, 32'h10,32'h0,32'hDEADBEEF};
    vecs[4] = '{0,0,0,0,      1,1,32'h20,32'h12345678,   0,0,1,0,1,1,1,0, 32'h20,32'h12345678,32'hDEADBEEF};
    vecs[5] = '{0,0,0,0,      1,1,32'h20,32'h12345678,   0,1,0,0,0,1,1,0, 32'h20,32'h12345678,32'hDEADBEEF};
    vecs[6] = '{1,0,32'h20,0, 0,0,0,0,                   0,0,0,0,0,1,0,1, 32'h20,32'h12345678,32'hDEADBEEF};
    vecs[7] = '{1,0,32'h20,0, 0,0,0,0,                   0,0,1,1,0,0,1,1, 32'h20,32'h0,32'hDEADBEEF};
    vecs[8] = '{1,0,32'h20,0, 0,0,0,0,                   1,0,0,0,0,0,1,0, 32'h20,32'h0,32'h12345678};
    vecs[9] = '{0,0,0,0,      0,0,0,0,                   0,0,0,0,0,0,0,0, 32'h20,32'h0,32'h12345678};

    reset1 = 1'b1; reset2 = 1'b1;
    cpuReq1 = 0; cpuWr1 = 0; cpuAddr1 = 0; cpuData1 = 0;
    ioReq1 = 0; ioWr1 = 0; ioAddr1 = 0; ioData1 = 0;
    cpuReq2 = 0; cpuAddr2 = 0;
    repeat (2) @(posedge sysClk);
    @(negedge sysClk);

    // Reset values
    checkOutput("rst_owner", owner1, 1'b1);
    checkOutput("rst_busy", busy1, 1'b0);
    checkOutput("rst_cs", dmCs1, 1'b0);
    checkOutput("rst_acks", {cpuAck1, ioAck1}, 2'b00);
    checkOutput("rst_rdata", rdata1, 32'h0);
    checkOutput("rst_addr", dmAddr1, 32'h0);
    checkOutput("rst_din", dmDin1, 32'h0);
    reset1 = 1'b0; reset2 = 1'b0;

    // Table-driven single transactions
    for (int i = 0; i < 10; i++) begin
      @(posedge sysClk); #1;
      applyStimulus(vecs[i]);
      @(negedge sysClk);
      checkVector(i, vecs[i]);
    end

    // Continuous dual requests from reset: grants alternate starting with CPU
    @(negedge sysClk); reset1 = 1'b1;
    @(negedge sysClk); reset1 = 1'b0;
    @(posedge sysClk); #1;
    cpuReq1 = 1; cpuWr1 = 0; cpuAddr1 = 32'h10;
    ioReq1 = 1; ioWr1 = 0; ioAddr1 = 32'h30;
    ackCount = 0;
    for (int c = 0; c < 60 && ackCount < 8; c++) begin
      @(negedge sysClk);
      checkOutput("dual_ack_overlap", {31'h0, cpuAck1 & ioAck1}, 32'h0);
      checkOutput("dual_rd_wr_overlap", {31'h0, dmRd1 & dmWr1}, 32'h0);
      if (cpuAck1 || ioAck1) begin
        expWho = ackCount % 2;
        checkOutput("dual_order", {31'h0, ioAck1}, expWho);
        checkOutput("dual_rdata", rdata1, (expWho == 0) ? 32'hDEADBEEF : 32'h0BADF00D);
        ackCount++;
      end
    end
    checkOutput("dual_ack_total", ackCount, 8);
    @(posedge sysClk); #1;
    cpuReq1 = 0; ioReq1 = 0;
    repeat (3) @(posedge sysClk);

    // IO request dropped and address changed mid-ACCESS
    #1;
    ioReq1 = 1; ioWr1 = 1; ioAddr1 = 32'h50; ioData1 = 32'hA5A5A5A5;
    @(posedge sysClk); #1;
    ioReq1 = 0; ioAddr1 = 32'h99;
    @(negedge sysClk);
    checkOutput("drop_cs", dmCs1, 1'b1);
    checkOutput("drop_addr", dmAddr1, 32'h50);
    checkOutput("drop_din", dmDin1, 32'hA5A5A5A5);
    @(negedge sysClk);
    checkOutput("drop_io_ack", ioAck1, 1'b1);
    checkOutput("drop_addr_hold", dmAddr1, 32'h50);
    @(negedge sysClk);
    checkOutput("drop_io_ack_once", ioAck1, 1'b0);
    checkOutput("drop_idle_cs", dmCs1, 1'b0);

    // ACC_CYC=3 read: cs held 3 cycles, data sampled on the last, ack at n+4
    @(posedge sysClk); #1;
    cpuReq2 = 1; cpuAddr2 = 32'h44;
    csCount = 0; ackCycle = -1; expRdata = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge sysClk);
      if (dmCs2) csCount++;
      if (k == 3) expRdata = dmDout2;
      if (cpuAck2 && ackCycle < 0) ackCycle = k;
      if (k == 4) begin
        checkOutput("acc3_rdata", rdata2, expRdata);
        cpuReq2 = 0;
      end
    end
    checkOutput("acc3_cs_cycles", csCount, 3);
    checkOutput("acc3_ack_cycle", ackCycle, 4);

    // Reset pulsed during the 2nd ACCESS cycle aborts without an ack
    @(posedge sysClk); #1;
    cpuReq2 = 1; cpuAddr2 = 32'h48;
    repeat (3) @(negedge sysClk);
    checkOutput("abort_pre_cs", dmCs2, 1'b1);
    reset2 = 1'b1;
    #1;
    checkOutput("abort_cs", dmCs2, 1'b0);
    checkOutput("abort_rd", dmRd2, 1'b0);
    checkOutput("abort_busy", busy2, 1'b0);
    checkOutput("abort_owner", owner2, 1'b1);
    checkOutput("abort_ack", cpuAck2, 1'b0);
    cpuReq2 = 0;
    @(negedge sysClk); reset2 = 1'b0;
    gotAcks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge sysClk);
      if (cpuAck2 || dmCs2) gotAcks++;
    end
    checkOutput("abort_no_activity", gotAcks, 0);

    // A fresh request after the abort completes normally
    @(posedge sysClk); #1;
    cpuReq2 = 1; cpuAddr2 = 32'h4C;
    ackCycle = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge sysClk);
      if (k == 3) expRdata = dmDout2;
      if (k == 1) checkOutput("fresh_owner", owner2, 1'b0);
      if (cpuAck2 && ackCycle < 0) ackCycle = k;
      if (k == 4) begin
        checkOutput("fresh_rdata", rdata2, expRdata);
        cpuReq2 = 0;
      end
    end
    checkOutput("fresh_ack_cycle", ackCycle, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
